ov7670_capture_scaler: RTL and testbench
========================================

Name: ov7670_capture_scaler

Overview:
- Parametrised next-generation OV7670 capture block, running in the camera pixel-clock domain.
- Assembles 8-bit camera bytes into 16-bit pixels and decimates by configurable integer factors in each axis.
- Applies a black crop window, optionally converts YUV422 luma to gray RGB565, and writes to a frame-buffer RAM port.
- Adds frame-boundary tracking, a frame counter and malformed-line detection.

Parameters:
- SRC_W, 640, source pixels per line (each pixel is 2 bytes).
- DST_W, 320, destination pixels per line.
- DST_H, 240, destination lines per frame.
- H_DEC, 2, horizontal decimation: keep source pixel x when x mod H_DEC == 0.
- V_DEC, 2, vertical decimation: keep source line y when y mod V_DEC == 0.
- ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= DST_W*DST_H.
- CROP_L, 0, destination columns forced black on the left.
- CROP_R, 0, destination columns forced black on the right.
- CROP_T, 0, destination lines forced black at the top.
- CROP_B, 0, destination lines forced black at the bottom.

Ports:
- pclk  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- vsync  in  1  camera VSYNC, high during vertical blank.
- href  in  1  camera HREF, high while line bytes are valid.
- d  in  8  camera data byte.
- enable  in  1  capture enable.
- fmt_sel  in  1  pixel format: 0 = RGB565 passthrough, 1 = YUV422 (Y0 U Y1 V order) to gray.
- addr  out  ADDR_W  RAM write address.
- dout  out  16  RAM write data, RGB565.
- we  out  1  RAM write strobe, one cycle per pixel.
- frame_done  out  1  one-cycle pulse at the end of a captured frame.
- frame_cnt  out  8  count of completed frames; wraps from 255 to 0.
- line_err  out  1  one-cycle pulse when a malformed line is detected.

Behaviour:
- Reset values (rst_n low, asynchronous): addr=0, dout=0, we=0, frame_done=0, frame_cnt=0, line_err=0; all counters 0; state SYNC.
- Input stage: vsync, href and d are registered on the rising edge of pclk. All logic below uses the registered copies (vs_r, hr_r, d_r).
- State SYNC: wait for vs_r=1, then go to VBLANK. No writes. This prevents capturing a partial frame after reset.
- State VBLANK: on vs_r falling (1 to 0):
  - If enable=1: latch fmt_sel, clear src_x, src_y, dst_x, dst_y and the byte phase, then go to ACTIVE.
  - If enable=0: stay in VBLANK.
- State ACTIVE, byte handling while hr_r=1:
  - Byte phase toggles each cycle; phase 0 is the high byte, phase 1 the low byte.
  - On phase 1, a pixel is complete and src_x increments.
- Pixel keep rule: keep when src_x mod H_DEC == 0, src_y mod V_DEC == 0, dst_x < DST_W and dst_y < DST_H. A kept pixel increments dst_x.
- Write output for a kept pixel:
  - we=1 for exactly one cycle, registered one pclk edge after the edge that captured the low byte into d_r.
  - addr = dst_y*DST_W + dst_x, computed at full width and truncated to ADDR_W.
- dout for a kept pixel:
  - If dst_x < CROP_L, or dst_x > DST_W-1-CROP_R, or dst_y < CROP_T, or dst_y > DST_H-1-CROP_B: dout=16'h0000.
  - Else, fmt_sel=0: dout = {high byte, low byte}.
  - Else, fmt_sel=1: with Y taken from the high (phase-0) byte, dout = {Y[7:3], Y[7:2], Y[7:3]}.
- Line end (hr_r falling in ACTIVE):
  - line_err pulses if the byte phase is odd or src_x != SRC_W.
  - src_y increments; if the finished line was a kept line, dst_y increments, saturating at DST_H.
  - src_x, dst_x and the byte phase clear.
  - Line processing continues normally after an error.
- Lines beyond DST_H kept lines and pixels beyond DST_W produce no writes. There is never an address wrap within a frame.
- Frame end (vs_r rising in ACTIVE): frame_done pulses one cycle, frame_cnt increments, state goes to VBLANK.
  - If href is still high at that edge, the partial line is dropped and line_err pulses in the same cycle.
- enable deasserted mid-frame: the current frame completes normally. enable is only checked at the next frame start.
- fmt_sel changes mid-frame have no effect until the next frame start.
- rst_n asserted mid-frame: all outputs clear immediately, we drops the same instant, state returns to SYNC.
- vsync and href high simultaneously: vsync has priority; no write occurs.

Test Plan:
- Use SRC_W=8, DST_W=4, DST_H=2, H_DEC=2, V_DEC=2 unless noted.
- Reset then one frame of 4 lines x 16 bytes, pixel value = {line, x}, fmt_sel=0: exactly 8 writes.
  - addr 0..7 with dout 16'h0000, 0002, 0004, 0006, 0200, 0202, 0204, 0206.
  - frame_done pulses once; frame_cnt=1.
- fmt_sel=1 with every Y byte = 8'hFF: every dout=16'hFFFF. With Y = 8'h80: every dout=16'h8410.
- CROP_L=1, CROP_T=1, same frame as the first scenario:
  - addr 0..4 write 16'h0000.
  - addr 5, 6, 7 write 16'h0202, 0204, 0206.
- Line with 15 bytes, then a line with 12 bytes: line_err pulses at each href fall. Following lines still write at the correct addresses.
- Release rst_n mid-frame (vsync low, href toggling): no we until a full vsync high-then-low is seen.
  - enable=0 at frame start: zero writes and no frame_done for that frame.
- 256 frames: frame_cnt wraps to 0 after frame 256. A 5th kept line with DST_H=2 produces no write and addr never exceeds 7.

Source files
------------

// File: rtl/ov7670_capture_scaler.sv
// ---------------------------------------------------------------------------
// ov7670_capture_scaler
//
// Captures an OV7670 byte stream in the camera pixel-clock domain. It pairs
// bytes into 16-bit pixels and decimates by H_DEC x V_DEC. Pixels that fall
// inside the crop margins are blacked out. YUV422 luma can be converted to
// gray RGB565. Each kept pixel is written to a frame-buffer RAM port.
// The block also tracks frame boundaries, counts completed frames and flags
// malformed lines.
//
// Ports:
//   pclk        pixel clock; all logic on its rising edge
//   rst_n       asynchronous active-low reset
//   vsync       camera VSYNC, high during vertical blank
//   href        camera HREF, high while line bytes are valid
//   d[7:0]      camera data byte
//   enable      capture enable, sampled at frame start
//   fmt_sel     0 = RGB565 passthrough, 1 = YUV422 (Y0 U Y1 V) to gray
//   addr        RAM write address
//   dout        RAM write data (RGB565)
//   we          RAM write strobe, one cycle per kept pixel
//   frame_done  one-cycle pulse at the end of a captured frame
//   frame_cnt   completed-frame counter, wraps 255 -> 0
//   line_err    one-cycle pulse on a malformed line
// ---------------------------------------------------------------------------
module ov7670_capture_scaler #(
    parameter int SRC_W  = 640,
    parameter int DST_W  = 320,
    parameter int DST_H  = 240,
    parameter int H_DEC  = 2,
    parameter int V_DEC  = 2,
    parameter int ADDR_W = 17,
    parameter int CROP_L = 0,
    parameter int CROP_R = 0,
    parameter int CROP_T = 0,
    parameter int CROP_B = 0
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              enable,
    input  logic              fmt_sel,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              line_err
);

    typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE} state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] SRC_W_C  = CW'(SRC_W);
    localparam logic [CW-1:0] DST_W_C  = CW'(DST_W);
    localparam logic [CW-1:0] DST_H_C  = CW'(DST_H);
    localparam logic [CW-1:0] H_DEC_C  = CW'(H_DEC);
    localparam logic [CW-1:0] V_DEC_C  = CW'(V_DEC);
    localparam logic [CW-1:0] CROP_L_C = CW'(CROP_L);
    localparam logic [CW-1:0] CROP_T_C = CW'(CROP_T);
    localparam logic [CW-1:0] X_LAST_C = CW'(DST_W - 1 - CROP_R);
    localparam logic [CW-1:0] Y_LAST_C = CW'(DST_H - 1 - CROP_B);

    state_t state_q, state_d;

    // Registered camera inputs plus one-cycle-delayed copies for edge detection.
    logic       vs_q, hr_q, vs_prev_q, hr_prev_q;
    logic [7:0] d_q;

    logic              fmt_q, fmt_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [CW-1:0]     src_x_q, src_x_d, src_y_q, src_y_d;
    logic [CW-1:0]     dst_x_q, dst_x_d, dst_y_q, dst_y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              line_err_q, line_err_d;

    logic              vs_rise, vs_fall, hr_fall;
    logic              y_keep, keep, in_crop;
    logic [ADDR_W-1:0] lin_addr;
    logic [15:0]       gray;

    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            hr_q      <= 1'b0;
            d_q       <= '0;
            vs_prev_q <= 1'b0;
            hr_prev_q <= 1'b0;
        end else begin
            vs_q      <= vsync;
            hr_q      <= href;
            d_q       <= d;
            vs_prev_q <= vs_q;
            hr_prev_q <= hr_q;
        end
    end

    assign vs_rise = vs_q & ~vs_prev_q;
    assign vs_fall = ~vs_q & vs_prev_q;
    assign hr_fall = ~hr_q & hr_prev_q;

    assign y_keep = (src_y_q % V_DEC_C) == '0;
    assign keep   = ((src_x_q % H_DEC_C) == '0) && y_keep &&
                    (dst_x_q < DST_W_C) && (dst_y_q < DST_H_C);

    // The "+1 <=" form expresses "< CROP" without a compare against zero
    // when a margin is unused.
    assign in_crop = (dst_x_q + 16'd1 <= CROP_L_C) || (dst_x_q > X_LAST_C) ||
                     (dst_y_q + 16'd1 <= CROP_T_C) || (dst_y_q > Y_LAST_C);

    assign lin_addr = ADDR_W'(32'(dst_y_q) * 32'(DST_W) + 32'(dst_x_q));
    assign gray     = {hi_q[7:3], hi_q[7:2], hi_q[7:3]};

    // NOTE: every signal assigned here gets its default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        fmt_d        = fmt_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        src_x_d      = src_x_q;
        src_y_d      = src_y_q;
        dst_x_d      = dst_x_q;
        dst_y_d      = dst_y_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        we_d         = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        line_err_d   = 1'b0;

        case (state_q)
            SYNC: begin
                // Wait for a blanking interval so a partial frame is never captured.
                if (vs_q) state_d = VBLANK;
            end
            VBLANK: begin
                if (vs_fall && enable) begin
                    fmt_d   = fmt_sel;
                    src_x_d = '0;
                    src_y_d = '0;
                    dst_x_d = '0;
                    dst_y_d = '0;
                    phase_d = 1'b0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    // VSYNC wins over HREF. Any line still in progress is dropped.
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    line_err_d   = hr_q;
                    state_d      = VBLANK;
                end else if (hr_q) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = d_q;
                    end else begin
                        if (src_x_q != '1) src_x_d = src_x_q + 16'd1;
                        if (keep) begin
                            we_d    = 1'b1;
                            addr_d  = lin_addr;
                            dout_d  = in_crop ? 16'h0000 : (fmt_q ? gray : {hi_q, d_q});
                            dst_x_d = dst_x_q + 16'd1;
                        end
                    end
                end else if (hr_fall) begin
                    line_err_d = phase_q || (src_x_q != SRC_W_C);
                    if (src_y_q != '1) src_y_d = src_y_q + 16'd1;
                    // dst_y stops at DST_H, so surplus lines never wrap the address.
                    if (y_keep && (dst_y_q < DST_H_C)) dst_y_d = dst_y_q + 16'd1;
                    src_x_d = '0;
                    dst_x_d = '0;
                    phase_d = 1'b0;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SYNC;
            fmt_q        <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            src_x_q      <= '0;
            src_y_q      <= '0;
            dst_x_q      <= '0;
            dst_y_q      <= '0;
            addr_q       <= '0;
            dout_q       <= '0;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fmt_q        <= fmt_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            src_x_q      <= src_x_d;
            src_y_q      <= src_y_d;
            dst_x_q      <= dst_x_d;
            dst_y_q      <= dst_y_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            we_q         <= we_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            line_err_q   <= line_err_d;
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign line_err   = line_err_q;

endmodule

// File: tb/tb_ov7670_capture_scaler.sv
// ---------------------------------------------------------------------------
// Bench for ov7670_capture_scaler. Two instances share the camera stimulus:
// dut uses no crop, and dut_c uses CROP_L=1, CROP_T=1. Expected RAM writes are
// queued by the stimulus process and popped by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_ov7670_capture_scaler;

    typedef struct packed {
        logic [16:0] a;
        logic [15:0] v;
    } wr_t;

    logic        pclk = 1'b0;
    logic        rst_n, vsync, href, enable, fmt_sel;
    logic [7:0]  d;
    logic [16:0] addr, addr_c;
    logic [15:0] dout, dout_c;
    logic        we, we_c, frame_done, frame_done_c, line_err, line_err_c;
    logic [7:0]  frame_cnt, frame_cnt_c;

    int  checks = 0;
    int  errors = 0;
    int  fd_cnt = 0;
    int  le_cnt = 0;
    wr_t q_main[$];
    wr_t q_crop[$];

    always #5 pclk = ~pclk;

    ov7670_capture_scaler #(
        .SRC_W(8), .DST_W(4), .DST_H(2), .H_DEC(2), .V_DEC(2), .ADDR_W(17),
        .CROP_L(0), .CROP_R(0), .CROP_T(0), .CROP_B(0)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
        .enable(enable), .fmt_sel(fmt_sel), .addr(addr), .dout(dout), .we(we),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .line_err(line_err)
    );

    ov7670_capture_scaler #(
        .SRC_W(8), .DST_W(4), .DST_H(2), .H_DEC(2), .V_DEC(2), .ADDR_W(17),
        .CROP_L(1), .CROP_R(0), .CROP_T(1), .CROP_B(0)
    ) dut_c (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
        .enable(enable), .fmt_sel(fmt_sel), .addr(addr_c), .dout(dout_c), .we(we_c),
        .frame_done(frame_done_c), .frame_cnt(frame_cnt_c), .line_err(line_err_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Main instance gets v at address a. The crop instance blacks out
    // column 0 and line 0 (addresses 0..3 and every multiple of 4).
    task automatic exp_pix(input int a, input logic [15:0] v);
        wr_t w;
        w.a = 17'(a);
        w.v = v;
        q_main.push_back(w);
        w.v = (a < 4 || (a % 4) == 0) ? 16'h0000 : v;
        q_crop.push_back(w);
    endtask

    // RGB frame with pixel = {src_line, src_x}: kept lines 0 and 2, kept x 0,2,4,6.
    task automatic exp_rgb_frame(input int nlines_kept);
        for (int k = 0; k < nlines_kept; k++)
            for (int x = 0; x < 4; x++)
                exp_pix(k * 4 + x, {8'(2 * k), 8'(2 * x)});
    endtask

    task automatic exp_const_frame(input logic [15:0] v);
        for (int a = 0; a < 8; a++) exp_pix(a, v);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_line(input int nbytes, input int src_line, input bit gray,
                             input logic [7:0] yv);
        for (int i = 0; i < nbytes; i++) begin
            href = 1'b1;
            if (i % 2 == 0) d = gray ? yv : 8'(src_line);
            else            d = gray ? 8'h80 : 8'(i / 2);
            tick();
        end
        href = 1'b0;
        d    = 8'h00;
        repeat (3) tick();
    endtask

    task automatic frame_open(input bit en, input bit fmt);
        enable  = en;
        fmt_sel = fmt;
        vsync   = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_close();
        vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic check_drained(input string name);
        check({name, "_main_pending"}, 32'(q_main.size()), 32'd0);
        check({name, "_crop_pending"}, 32'(q_crop.size()), 32'd0);
    endtask

    // Monitor: samples outputs on the falling edge, away from the active edge.
    always @(negedge pclk) begin
        if (we) begin
            if (q_main.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_spurious_write: got addr=%0h dout=%0h, expected no write",
                         addr, dout);
            end else begin
                wr_t e;
                e = q_main.pop_front();
                check("main_addr", 32'(addr), 32'(e.a));
                check("main_dout", 32'(dout), 32'(e.v));
            end
        end
        if (we_c) begin
            if (q_crop.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL crop_spurious_write: got addr=%0h dout=%0h, expected no write",
                         addr_c, dout_c);
            end else begin
                wr_t e;
                e = q_crop.pop_front();
                check("crop_addr", 32'(addr_c), 32'(e.a));
                check("crop_dout", 32'(dout_c), 32'(e.v));
            end
        end
        if (frame_done) fd_cnt++;
        if (line_err)   le_cnt++;
    end

    initial begin
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; d = 8'h00; enable = 1'b1; fmt_sel = 1'b0;
        repeat (3) tick();
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_line_err", 32'(line_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // RGB565 passthrough frame, 4 lines x 16 bytes.
        exp_rgb_frame(2);
        frame_open(1'b1, 1'b0);
        for (int l = 0; l < 4; l++) send_line(16, l, 1'b0, 8'h00);
        frame_close();
        check_drained("rgb");
        check("rgb_frame_done", 32'(fd_cnt), 32'd1);
        check("rgb_frame_cnt", 32'(frame_cnt), 32'd1);
        check("rgb_crop_frame_cnt", 32'(frame_cnt_c), 32'd1);
        check("rgb_line_err", 32'(le_cnt), 32'd0);

        // Gray conversion, Y = FF.
        exp_const_frame(16'hFFFF);
        frame_open(1'b1, 1'b1);
        for (int l = 0; l < 4; l++) send_line(16, l, 1'b1, 8'hFF);
        frame_close();
        check_drained("gray_ff");

        // Gray conversion, Y = 80. fmt_sel and enable flip mid-frame, which
        // must not affect this frame.
        exp_const_frame(16'h8410);
        frame_open(1'b1, 1'b1);
        fmt_sel = 1'b0;
        enable  = 1'b0;
        for (int l = 0; l < 4; l++) send_line(16, l, 1'b1, 8'h80);
        frame_close();
        check_drained("gray_80");
        check("gray_frame_cnt", 32'(frame_cnt), 32'd3);

        // Malformed lines: 15 bytes (odd phase) then 12 bytes (short).
        exp_rgb_frame(2);
        frame_open(1'b1, 1'b0);
        send_line(15, 0, 1'b0, 8'h00);
        send_line(12, 1, 1'b0, 8'h00);
        send_line(16, 2, 1'b0, 8'h00);
        send_line(16, 3, 1'b0, 8'h00);
        frame_close();
        check_drained("malformed");
        check("malformed_line_err", 32'(le_cnt), 32'd2);

        // VSYNC rises together with HREF: the partial line is dropped.
        exp_rgb_frame(1);
        frame_open(1'b1, 1'b0);
        send_line(16, 0, 1'b0, 8'h00);
        send_line(16, 1, 1'b0, 8'h00);
        vsync = 1'b1;
        href  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 8'hA5;
            tick();
        end
        href = 1'b0;
        frame_close();
        check_drained("vs_priority");
        check("vs_priority_line_err", 32'(le_cnt), 32'd3);
        check("vs_priority_frame_done", 32'(fd_cnt), 32'd5);

        // Capture disabled at frame start.
        frame_open(1'b0, 1'b0);
        for (int l = 0; l < 4; l++) send_line(16, l, 1'b0, 8'h00);
        frame_close();
        check("disabled_frame_done", 32'(fd_cnt), 32'd5);
        check("disabled_frame_cnt", 32'(frame_cnt), 32'd5);

        // Ten lines: kept lines beyond DST_H must not write.
        exp_rgb_frame(2);
        frame_open(1'b1, 1'b0);
        for (int l = 0; l < 10; l++) send_line(16, l, 1'b0, 8'h00);
        frame_close();
        check_drained("dst_h_sat");
        check("dst_h_sat_frame_cnt", 32'(frame_cnt), 32'd6);

        // Reset asserted while a write strobe is high.
        frame_open(1'b1, 1'b0);
        href = 1'b1;
        d = 8'h01; tick();
        d = 8'h23; tick();
        d = 8'h01; tick();
        check("pre_reset_we", 32'(we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_we_async", 32'(we), 32'd0);
        check("reset_dout_async", 32'(dout), 32'd0);
        check("reset_frame_cnt_async", 32'(frame_cnt), 32'd0);
        href  = 1'b0;
        vsync = 1'b0;
        tick();
        // Release with VSYNC low and HREF toggling: no capture yet.
        rst_n = 1'b1;
        send_line(16, 0, 1'b0, 8'h00);
        send_line(16, 1, 1'b0, 8'h00);
        check("post_reset_frame_done", 32'(fd_cnt), 32'd6);
        exp_rgb_frame(2);
        frame_open(1'b1, 1'b0);
        for (int l = 0; l < 4; l++) send_line(16, l, 1'b0, 8'h00);
        frame_close();
        check_drained("post_reset");
        check("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);

        // Empty frames up to and across the 8-bit wrap.
        for (int f = 0; f < 254; f++) begin
            frame_open(1'b1, 1'b0);
            frame_close();
        end
        check("frame_cnt_255", 32'(frame_cnt), 32'd255);
        frame_open(1'b1, 1'b0);
        frame_close();
        check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        check("frame_done_total", 32'(fd_cnt), 32'd262);
        check_drained("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
